keypad_display_ctrl: RTL

Controller between the keypad front end (scanner plus key decoder) and the dual seven-segment display. It accepts one-cycle confirmed-key events and keeps the two most recent hex keys. It also time-multiplexes a single shared seven-segment decoder across the left and right digits. A blanking gap between digit phases prevents ghosting.

---
 rtl/keypad_display_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/keypad_display_ctrl.sv
// Keypad-to-display controller: keeps the two most recent hex keys and time-multiplexes
// one shared seven-segment decoder across the left and right digits with a dark gap between.
module keypad_display_ctrl #(
  parameter int unsigned MUX_PERIOD = 48000,
  parameter int unsigned GAP_CYCLES = 480
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyValid,
  input  logic [3:0] keyCode,
  output logic [3:0] digitVal,
  output logic       blank,
  output logic [1:0] anode,
  output logic [3:0] newest,
  output logic [3:0] older,
  output logic [1:0] loaded
);

  localparam logic [1:0] StShowL = 2'd0;
  localparam logic [1:0] StGapLR = 2'd1;
  localparam logic [1:0] StShowR = 2'd2;
  localparam logic [1:0] StGapRL = 2'd3;

  localparam logic [15:0] MuxLast = 16'(MUX_PERIOD - 1);
  localparam logic [15:0] GapLast = 16'(GAP_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q;
  logic        phase_last;
  logic [3:0]  digit_d;
  logic        blank_d;
  logic [1:0]  anode_d;

  // Key history shifts on every pulse, back-to-back pulses included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      newest <= 4'h0;
      older  <= 4'h0;
      loaded <= 2'b00;
    end else if (keyValid) begin
      older  <= newest;
      newest <= keyCode;
      loaded <= {loaded[0], 1'b1};
    end
  end

  always_comb begin
    phase_last = (state_q == StShowL || state_q == StShowR) ? (cnt_q == MuxLast)
                                                            : (cnt_q == GapLast);
    state_d = state_q;
    unique case (state_q)
      StShowL: state_d = StGapLR;
      StGapLR: state_d = StShowR;
      StShowR: state_d = StGapRL;
      StGapRL: state_d = StShowL;
      default: state_d = StGapRL;
    endcase
  end

  // Display outputs only change on the entering edge, so a key landing mid-phase
  // waits for the next SHOW entry of its digit.
  always_comb begin
    digit_d = digitVal;
    blank_d = 1'b1;
    anode_d = 2'b11;
    unique case (state_d)
      StShowL: begin
        digit_d = older;
        blank_d = !loaded[1];
        anode_d = loaded[1] ? 2'b01 : 2'b11;
      end
      StShowR: begin
        digit_d = newest;
        blank_d = !loaded[0];
        anode_d = loaded[0] ? 2'b10 : 2'b11;
      end
      default: begin
        blank_d = 1'b1;
        anode_d = 2'b11;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StGapRL;
      cnt_q    <= 16'h0000;
      digitVal <= 4'h0;
      blank    <= 1'b1;
      anode    <= 2'b11;
    end else if (phase_last) begin
      state_q  <= state_d;
      cnt_q    <= 16'h0000;
      digitVal <= digit_d;
      blank    <= blank_d;
      anode    <= anode_d;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule
